// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests and buffers in-order responses
// for the decoder. It also handles redirects, stale-response discard and halt-on-fault.
package instr_fetch_queue_pkg;

    typedef logic [3:0] if_reason_t;

    localparam if_reason_t IF_PREFETCH = 4'b0000;
    localparam if_reason_t IF_FLUSH    = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [5:0] mcause_code;
    } exception_t;

    typedef struct packed {
        logic        taken;
        logic [63:0] target;
    } prediction_t;

    typedef struct packed {
        logic [63:0] pc;
        if_reason_t  if_reason;
        logic [31:0] instr_word;
        prediction_t prediction;
        exception_t  exception;
    } fetched_instr_t;

endpackage

module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           redirect_valid_i,
    input  logic [63:0]    redirect_pc_i,
    input  if_reason_t     redirect_reason_i,
    output logic           req_valid_o,
    input  logic           req_ready_i,
    output logic [63:0]    req_pc_o,
    input  logic           resp_valid_i,
    input  logic [31:0]    resp_instr_i,
    input  exception_t     resp_exception_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output fetched_instr_t out_instr_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Discard can accumulate across back-to-back redirects, so it gets extra headroom.
    localparam int unsigned DW = AW + 4;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t         r_state;
    logic [63:0]    r_fetch_pc;
    logic [63:0]    r_resp_pc;
    if_reason_t     r_next_reason;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_outstanding;
    logic [DW-1:0]  r_discard;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    fetched_instr_t r_mem [DEPTH];

    logic [CW:0]    w_inflight;
    logic           w_issue;
    logic           w_pop;
    logic           w_resp_drop;
    logic           w_resp_acc;
    logic           w_resp_fault;
    logic           w_enq;
    fetched_instr_t w_enq_entry;
    logic [CW-1:0]  w_out_next;
    logic [CW-1:0]  w_count_next;
    logic [DW-1:0]  w_disc_sum;
    logic [DW-1:0]  w_disc_redir;
    logic [63:0]    w_redir_pc;

    assign w_inflight   = {1'b0, r_count} + {1'b0, r_outstanding};
    assign req_valid_o  = !rst_i && (r_state == ST_RUN) && (w_inflight < DEPTH_W) && !redirect_valid_i;
    assign req_pc_o     = {r_fetch_pc[63:2], 2'b00};
    assign out_valid_o  = !rst_i && (r_count != '0) && !redirect_valid_i;
    assign out_instr_o  = r_mem[r_rd_ptr];

    assign w_issue      = req_valid_o && req_ready_i;
    assign w_pop        = out_valid_o && out_ready_i;
    assign w_resp_drop  = resp_valid_i && (r_discard != '0);
    assign w_resp_acc   = resp_valid_i && (r_discard == '0);
    assign w_resp_fault = w_resp_acc && resp_exception_i.valid;
    assign w_enq        = w_resp_acc && !redirect_valid_i && !rst_i;
    assign w_redir_pc   = {redirect_pc_i[63:2], 2'b00};
    assign w_disc_sum   = r_discard + DW'(r_outstanding);

    // Entry built from the current response and the tracked response address.
    always_comb begin
        w_enq_entry            = '0;
        w_enq_entry.pc         = r_resp_pc;
        w_enq_entry.if_reason  = r_next_reason;
        w_enq_entry.instr_word = resp_instr_i;
        w_enq_entry.prediction = '0;
        w_enq_entry.exception  = resp_exception_i;
    end

    // Next outstanding count and queue occupancy for the non-redirect path.
    always_comb begin
        w_out_next = r_outstanding;
        if (w_issue && !w_resp_acc) begin
            w_out_next = r_outstanding + CW'(1);
        end else if (!w_issue && w_resp_acc) begin
            w_out_next = r_outstanding - CW'(1);
        end else begin
            w_out_next = r_outstanding;
        end
        case ({w_enq, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // On redirect every in-flight response becomes stale, less one arriving right now.
    always_comb begin
        w_disc_redir = w_disc_sum;
        if (resp_valid_i && (w_disc_sum != '0)) begin
            w_disc_redir = w_disc_sum - DW'(1);
        end else begin
            w_disc_redir = w_disc_sum;
        end
    end

    // Queue storage; occupancy is tracked by the control registers.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_enq_entry;
        end
    end

    // Fetch control state: pcs, counters, pointers and the RUN/HALT state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_next_reason <= IF_FLUSH;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect_valid_i) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= w_redir_pc;
            r_resp_pc     <= w_redir_pc;
            r_next_reason <= redirect_reason_i;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= w_disc_redir;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 64'd4;
            end
            if (w_resp_acc) begin
                r_resp_pc     <= r_resp_pc + 64'd4;
                r_next_reason <= IF_PREFETCH;
            end
            // A fault turns every request still in flight into a discard.
            if (w_resp_drop) begin
                r_discard <= r_discard - DW'(1);
            end else if (w_resp_fault) begin
                r_discard <= DW'(w_out_next);
            end
            if (w_resp_fault) begin
                r_state       <= ST_HALT;
                r_outstanding <= '0;
            end else begin
                r_outstanding <= w_out_next;
            end
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 64'h0: first fetch address after reset.
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports: clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-004 SHALL have redirect_valid_i  in  1  redirect request.
REQ-005 SHALL have redirect_pc_i  in  64  redirect target.
REQ-006 SHALL have redirect_reason_i  in  if_reason_t  reason attached to the first instruction after the redirect.
REQ-007 SHALL have req_valid_o  out  1, req_ready_i  in  1, req_pc_o  out  64: fetch request channel.
REQ-008 SHALL have resp_valid_i  in  1, resp_instr_i  in  32, resp_exception_i  in  exception_t: in-order fetch response channel, no ready.
REQ-009 SHALL have out_valid_o  out  1, out_ready_i  in  1, out_instr_o  out  fetched_instr_t: stream to decoder.

Function
REQ-010 SHALL have two states: RUN (issues requests) and HALT (entered after queuing a faulting fetch; issues nothing).
REQ-011 SHALL assert req_valid_o = (state==RUN) && (count+outstanding < DEPTH) && !redirect_valid_i.
REQ-012 SHALL count a request issued when req_valid_o && req_ready_i; fetch_pc SHALL then advance by 4, modulo 2^64.
REQ-013 SHALL drive req_pc_o = fetch_pc with bits [1:0] forced to 0.
REQ-014 SHALL track outstanding (0..DEPTH): +1 per issued request, -1 per accepted response; both in the same cycle leave it unchanged.
REQ-015 SHALL drop a response while discard>0, decrementing discard; it SHALL NOT change outstanding or resp_pc.
REQ-016 SHALL enqueue an accepted response as {pc=resp_pc, if_reason=next_reason, instr_word=resp_instr_i, prediction={0,0}, exception=resp_exception_i}, then advance resp_pc by 4 and set next_reason to 4'b0000 (IF_PREFETCH).
REQ-017 SHALL make an enqueued entry visible on out_valid_o the next cycle (1-cycle latency, no bypass).
REQ-018 SHALL, when an enqueued response has exception.valid=1, enter HALT and set discard to the requests still outstanding after that response.
REQ-019 SHALL drive out_valid_o = (count!=0) && !redirect_valid_i and out_instr_o = queue head; the head SHALL pop on out_valid_o && out_ready_i.
REQ-020 SHALL allow enqueue and dequeue in the same cycle. Overflow is impossible by REQ-011; the queue SHALL NOT rely on the full flag.
REQ-021 SHALL give redirect_valid_i priority over all other events in its cycle:
  - queue cleared
  - fetch_pc and resp_pc set to {redirect_pc_i[63:2],2'b00}
  - next_reason set to redirect_reason_i
  - state set to RUN
  - discard set to discard+outstanding minus 1 if a response arrives that cycle (that response dropped)
  - outstanding cleared
  - no request issued, no pop
REQ-022 SHALL accept a redirect while in HALT or while discard>0.
REQ-023 SHALL keep the queue as a circular buffer with wrapping read/write pointers and a count of 0..DEPTH.

Reset
REQ-024 SHALL, on rst_i, asynchronously set:
  - state=RUN
  - fetch_pc=resp_pc=RESET_PC
  - next_reason=4'b1111 (IF_FLUSH)
  - count=outstanding=discard=0
  - pointers=0
REQ-025 SHALL hold out_valid_o=0 during reset; req_valid_o SHALL be 0 during reset and 1 from the first cycle after reset deassertion.
REQ-026 SHALL return to the reset state when rst_i is asserted mid-operation, with no queued or outstanding state retained.

Verification
REQ-027 Reset with RESET_PC=64'h8000_0000 -> req_valid_o=1, req_pc_o=64'h8000_0000, out_valid_o=0.
REQ-028 4 requests, each response 1 cycle later, out_ready_i=1 -> out pcs 0x8000_0000..0x8000_000C; reasons 4'b1111, then 4'b0000 x3; prediction.taken=0.
REQ-029 out_ready_i=0, DEPTH=4 -> exactly 4 requests, then req_valid_o=0; one pop re-enables exactly one request.
REQ-030 Redirect to 64'h1000 with reason 4'b0001 and 2 outstanding -> next 2 responses dropped, req_pc_o=64'h1000, first output pc=64'h1000 with if_reason=4'b0001.
REQ-031 Response at pc 0x8000_0004 with exception.valid=1, mcause_code=1, 1 still outstanding -> entry output with exception intact, trailing response dropped, req_valid_o=0 until redirect.
REQ-032 Redirect to 64'hFFFF_FFFF_FFFF_FFFC -> second request pc=64'h0; response pcs wrap identically.
